// File: rtl/constraint_split_sched.sv
// Constraint-split check sequencer.
// Latches candidate assignments from a candidate source into the shared holding register
// (via cand_latch_o), then walks the split select mux one split at a time, waiting SETTLE
// cycles after every select/latch change before sampling the muxed pass bit. Stops at the
// first failing split and retries with a new candidate until MAX_TRIES candidates have been
// consumed, then reports one verdict.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start_i           begin a solve (only honoured while idle)
//   abort_i           cancel the current solve; overrides everything else
//   cand_valid_i      candidate available;  cand_ready_o: candidate accepted this cycle
//   cand_latch_o      one-cycle pulse to capture the accepted candidate
//   split_sel_o       split select;  split_x_i: pass bit of the selected split
//   res_valid_o       verdict available;  res_ready_i: verdict consumed
//   res_pass_o        all splits passed
//   res_tries_o       candidates consumed by this solve
//   res_fail_idx_o    split that rejected the last candidate (0 on pass)
//   busy_o            high whenever not idle
module constraint_split_sched #(
  parameter int unsigned NUM_SPLITS = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned SETTLE     = 1,
  parameter int unsigned MAX_TRIES  = 1024,
  parameter int unsigned TRY_W      = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cand_valid_i,
  output logic             cand_ready_o,
  output logic             cand_latch_o,
  output logic [SEL_W-1:0] split_sel_o,
  input  logic             split_x_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_pass_o,
  output logic [TRY_W-1:0] res_tries_o,
  output logic [SEL_W-1:0] res_fail_idx_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(SETTLE + 1);
  localparam logic [SEL_W-1:0] LastSel  = SEL_W'(NUM_SPLITS - 1);
  localparam logic [TRY_W-1:0] MaxTries = TRY_W'(MAX_TRIES);
  localparam logic [CntW-1:0]  SettleLd = CntW'(SETTLE);

  typedef enum logic [2:0] {
    StIdle,
    StWaitCand,
    StSettle,
    StCheck,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             latch_q, latch_d;
  logic             pass_q, pass_d;
  logic [TRY_W-1:0] rtries_q, rtries_d;
  logic [SEL_W-1:0] fidx_q, fidx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  assign cand_ready_o = (state_q == StWaitCand) && !abort_i;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    tries_d  = tries_q;
    cnt_d    = cnt_q;
    latch_d  = 1'b0;
    pass_d   = pass_q;
    rtries_d = rtries_q;
    fidx_d   = fidx_q;

    if (abort_i && (state_q != StIdle)) begin
      // Abort freezes everything except the state; a pending verdict is dropped.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d = StWaitCand;
            tries_d = '0;
          end
        end
        StWaitCand: begin
          if (cand_valid_i) begin
            latch_d = 1'b1;
            tries_d = tries_q + TRY_W'(1);
            sel_d   = '0;
            cnt_d   = SettleLd;
            state_d = StSettle;
          end
        end
        StSettle: begin
          if (cnt_q <= CntW'(1)) begin
            state_d = StCheck;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StCheck: begin
          if (split_x_i) begin
            if (sel_q == LastSel) begin
              state_d  = StDone;
              pass_d   = 1'b1;
              fidx_d   = '0;
              rtries_d = tries_q;
            end else begin
              sel_d   = sel_q + SEL_W'(1);
              cnt_d   = SettleLd;
              state_d = StSettle;
            end
          end else if (tries_q >= MaxTries) begin
            state_d  = StDone;
            pass_d   = 1'b0;
            fidx_d   = sel_q;
            rtries_d = tries_q;
          end else begin
            // sel_q keeps the rejecting split until the next candidate is accepted.
            state_d = StWaitCand;
          end
        end
        StDone: begin
          if (res_ready_i) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    valid_d = (state_d == StDone);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      tries_q  <= '0;
      cnt_q    <= '0;
      latch_q  <= 1'b0;
      pass_q   <= 1'b0;
      rtries_q <= '0;
      fidx_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      tries_q  <= tries_d;
      cnt_q    <= cnt_d;
      latch_q  <= latch_d;
      pass_q   <= pass_d;
      rtries_q <= rtries_d;
      fidx_q   <= fidx_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign cand_latch_o   = latch_q;
  assign split_sel_o    = sel_q;
  assign res_valid_o    = valid_q;
  assign res_pass_o     = pass_q;
  assign res_tries_o    = rtries_q;
  assign res_fail_idx_o = fidx_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_constraint_split_sched.sv
// Bench for constraint_split_sched: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against an elapsed-cycle behavioural model.
module tb_constraint_split_sched;

  localparam int NS = 4;
  localparam int S  = 1;
  localparam int MT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        cand_valid_i = 1'b0;
  logic        cand_ready_o;
  logic        cand_latch_o;
  logic [1:0]  split_sel_o;
  logic        split_x_i;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic        res_pass_o;
  logic [10:0] res_tries_o;
  logic [1:0]  res_fail_idx_o;
  logic        busy_o;

  constraint_split_sched #(
    .NUM_SPLITS(NS),
    .SEL_W     (2),
    .SETTLE    (S),
    .MAX_TRIES (MT),
    .TRY_W     (11)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .cand_valid_i  (cand_valid_i),
    .cand_ready_o  (cand_ready_o),
    .cand_latch_o  (cand_latch_o),
    .split_sel_o   (split_sel_o),
    .split_x_i     (split_x_i),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_pass_o    (res_pass_o),
    .res_tries_o   (res_tries_o),
    .res_fail_idx_o(res_fail_idx_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int latch_cnt = 0;

  // Candidate = per-split pass mask; the holding register captures it on cand_latch.
  logic [3:0] offered = 4'hF;
  logic [3:0] held    = 4'hF;
  assign split_x_i = held[split_sel_o];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cand_latch_o) begin
      held      <= offered;
      latch_cnt <= latch_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int first_fail(input logic [3:0] m);
    for (int i = 0; i < NS; i++) if (!m[i]) return i;
    return NS;
  endfunction

  // Behavioural model: phases 0 idle, 1 waiting for candidate, 2 evaluating, 3 verdict.
  // While evaluating, outputs follow from the cycles elapsed since the accept.
  int         m_phase = 0;
  int         m_tries = 0;
  int         m_sel_hold = 0;
  logic [3:0] m_mask = 4'hF;
  int         m_d = 0;
  int         m_pass = 0;
  int         m_rtries = 0;
  int         m_fidx = 0;

  always @(negedge clk) begin
    int exp_sel;
    int f;
    int last;
    if (!rst_n) begin
      m_phase = 0; m_tries = 0; m_sel_hold = 0; m_d = 0;
      m_pass = 0; m_rtries = 0; m_fidx = 0;
    end
    exp_sel = (m_phase == 2) ? (m_d - 1) / (S + 1) : m_sel_hold;
    chk("busy", busy_o, int'(m_phase != 0));
    chk("cand_ready", cand_ready_o, int'(m_phase == 1 && !abort_i));
    chk("cand_latch", cand_latch_o, int'(m_phase == 2 && m_d == 1));
    chk("split_sel", split_sel_o, exp_sel);
    chk("res_valid", res_valid_o, int'(m_phase == 3));
    chk("res_pass", res_pass_o, m_pass);
    chk("res_tries", res_tries_o, m_rtries);
    chk("res_fail_idx", res_fail_idx_o, m_fidx);
    if (rst_n) begin
      if (m_phase != 0 && abort_i) begin
        m_sel_hold = exp_sel;
        m_phase = 0;
      end else begin
        case (m_phase)
          0: if (start_i) begin m_phase = 1; m_tries = 0; end
          1: if (cand_valid_i) begin
            m_phase = 2; m_tries++; m_mask = offered; m_d = 1;
          end
          2: begin
            f    = first_fail(m_mask);
            last = (f < NS) ? f : NS - 1;
            if (m_d == (last + 1) * (S + 1)) begin
              m_sel_hold = last;
              if (f == NS) begin
                m_phase = 3; m_pass = 1; m_rtries = m_tries; m_fidx = 0;
              end else if (m_tries == MT) begin
                m_phase = 3; m_pass = 0; m_rtries = m_tries; m_fidx = f;
              end else begin
                m_phase = 1;
              end
            end else begin
              m_d++;
            end
          end
          3: if (res_ready_i) m_phase = 0;
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Offer one candidate; returns the accept cycle and leaves time in the latch cycle.
  task automatic offer(input logic [3:0] m, output int t_acc);
    bit got;
    got   = 1'b0;
    t_acc = -1;
    if (cand_latch_o) step();
    offered      = m;
    cand_valid_i = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      if (cand_ready_o) begin
        t_acc = cyc;
        got   = 1'b1;
      end
      step();
    end
    cand_valid_i = 1'b0;
    if (!got) chk("accept_wait", cand_ready_o, 1);
  endtask

  task automatic wait_result(output int vcyc);
    vcyc = -1;
    for (int n = 0; n < 200 && vcyc < 0; n++) begin
      if (res_valid_o) vcyc = cyc;
      else step();
    end
    if (vcyc < 0) chk("result_wait", res_valid_o, 1);
  endtask

  task automatic take_result();
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
  endtask

  initial begin
    int t;
    int t2;
    int v;
    int lc;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_sel", split_sel_o, 0);
    chk("rst_valid", res_valid_o, 0);
    chk("rst_tries", res_tries_o, 0);
    chk("rst_latch", cand_latch_o, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 1: all splits pass
    do_start();
    offer(4'b1111, t);
    chk("t1_latch_pulse", cand_latch_o, 1);
    step();
    chk("t1_sel0", split_sel_o, 0);
    for (int k = 1; k < NS; k++) begin
      step(); step();
      chk("t1_sel_step", split_sel_o, k);
    end
    wait_result(v);
    chk("t1_latency", v - t, 9);
    chk("t1_pass", res_pass_o, 1);
    chk("t1_tries", res_tries_o, 1);
    chk("t1_fidx", res_fail_idx_o, 0);
    take_result();

    // 2: first candidate rejected at split 2, second passes
    lc = latch_cnt;
    do_start();
    offer(4'b1011, t);
    offer(4'b1111, t2);
    chk("t2_retry_gap", t2 - t, 3 * (S + 1) + 1);
    wait_result(v);
    chk("t2_latches", latch_cnt - lc, 2);
    chk("t2_pass", res_pass_o, 1);
    chk("t2_tries", res_tries_o, 2);
    take_result();

    // 3: every candidate fails split 0 until the try limit
    do_start();
    offer(4'b0000, t);
    offer(4'b0000, t);
    offer(4'b0000, t);
    cand_valid_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      chk("t3_ready_low", cand_ready_o, 0);
      if (!res_valid_o) step();
    end
    cand_valid_i = 1'b0;
    wait_result(v);
    chk("t3_pass", res_pass_o, 0);
    chk("t3_tries", res_tries_o, 3);
    chk("t3_fidx", res_fail_idx_o, 0);
    take_result();

    // 4: backpressure on the verdict, start ignored
    do_start();
    offer(4'b1110, t);
    offer(4'b1111, t);
    wait_result(v);
    for (int n = 0; n < 5; n++) begin
      start_i = (n == 2);
      chk("t4_valid_held", res_valid_o, 1);
      chk("t4_pass_held", res_pass_o, 1);
      chk("t4_tries_held", res_tries_o, 2);
      chk("t4_fidx_held", res_fail_idx_o, 0);
      step();
    end
    start_i = 1'b0;
    take_result();
    chk("t4_busy_after", busy_o, 0);
    chk("t4_valid_after", res_valid_o, 0);

    // 5: abort in SETTLE with a candidate pending
    do_start();
    offer(4'b1111, t);
    abort_i      = 1'b1;
    cand_valid_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("t5_idle_busy", busy_o, 0);
    chk("t5_ready_low", cand_ready_o, 0);
    step();
    chk("t5_no_valid", res_valid_o, 0);
    cand_valid_i = 1'b0;
    do_start();
    offer(4'b1111, t);
    wait_result(v);
    chk("t5_tries_restart", res_tries_o, 1);
    take_result();

    // 6: asynchronous reset while checking split 2
    do_start();
    offer(4'b1111, t);
    repeat (5) step();
    chk("t6_pre_busy", busy_o, 1);
    chk("t6_pre_sel", split_sel_o, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy_o, 0);
    chk("t6_sel", split_sel_o, 0);
    chk("t6_valid", res_valid_o, 0);
    chk("t6_pass", res_pass_o, 0);
    chk("t6_tries", res_tries_o, 0);
    chk("t6_fidx", res_fail_idx_o, 0);
    repeat (2) step();
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      step();
      chk("t6_idle", busy_o, 0);
    end

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      step();
      if (!cand_valid_i && !cand_latch_o) begin
        for (int b = 0; b < 4; b++) offered[b] = ($urandom_range(7) != 0);
      end
      start_i      = ($urandom_range(3) == 0);
      cand_valid_i = ($urandom_range(2) != 0);
      res_ready_i  = ($urandom_range(2) == 0);
      abort_i      = ($urandom_range(49) == 0);
    end
    start_i      = 1'b0;
    cand_valid_i = 1'b0;
    res_ready_i  = 1'b0;
    abort_i      = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/constraint_split_sched.md
Name: constraint_split_sched

Overview:
- Sequencer that checks candidate variable assignments against a set of constraint-split evaluators (combinational split_* blocks, each producing one AND-reduced pass bit x).
- Accepts candidates from the random/BDD candidate source, latches each one into the shared holding register that feeds all splits, then walks the split select mux one split at a time.
- Exits early on the first failing split, retries with new candidates up to a limit, and returns a single pass/fail verdict to the solver controller.

Parameters:
- NUM_SPLITS, 4, number of split evaluators behind the select mux (≥1).
- SEL_W, 2, width of split_sel; must satisfy 2^SEL_W ≥ NUM_SPLITS.
- SETTLE, 1, cycles between a select or latch change and sampling split_x (≥1).
- MAX_TRIES, 1024, maximum candidates consumed per start (≥1).
- TRY_W, 11, width of the tries counter; must hold MAX_TRIES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a solve; sampled only in IDLE.
- abort  in  1  cancel the current solve; highest priority.
- cand_valid  in  1  candidate source has an assignment ready.
- cand_ready  out  1  block accepts a candidate this cycle.
- cand_latch  out  1  one-cycle pulse; holding register captures the candidate.
- split_sel  out  SEL_W  selects which split's x drives split_x.
- split_x  in  1  muxed pass bit of the selected split.
- res_valid  out  1  verdict available.
- res_ready  in  1  consumer takes the verdict.
- res_pass  out  1  1 = candidate satisfied all splits.
- res_tries  out  TRY_W  candidates consumed in this solve.
- res_fail_idx  out  SEL_W  split that rejected the last candidate; 0 on pass.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All registered outputs are 0: cand_latch, split_sel, res_valid, res_pass, res_tries, res_fail_idx, busy. Internal tries and settle counters are 0.
- Output timing: all outputs are registered except cand_ready. cand_ready = (state==WAIT_CAND) && !abort.
- Handshake: a candidate is accepted when cand_valid && cand_ready. The result is consumed when res_valid && res_ready.
- FSM states: IDLE, WAIT_CAND, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 → WAIT_CAND; tries cleared to 0.
  - start is ignored in every other state.
- WAIT_CAND, on accept:
  - cand_latch pulses the next cycle.
  - tries is incremented; split_sel=0; settle counter loaded with SETTLE.
  - Next state: SETTLE.
- SETTLE: lasts exactly SETTLE cycles, then CHECK.
- CHECK: samples split_x for one cycle.
  - split_x=1 and split_sel<NUM_SPLITS-1 → split_sel+1, reload settle counter, go to SETTLE.
  - split_x=1 and split_sel==NUM_SPLITS-1 → DONE with res_pass=1, res_fail_idx=0.
  - split_x=0 and tries<MAX_TRIES → WAIT_CAND; split_fail index held internally.
  - split_x=0 and tries==MAX_TRIES → DONE with res_pass=0, res_fail_idx=split_sel.
- DONE:
  - res_valid=1; res_pass, res_tries and res_fail_idx are held stable until the handshake.
  - On handshake → IDLE; res_valid drops the next cycle.
  - Other result outputs keep their values until the next result is written.
- Latency: candidate accepted at cycle T, all splits passing → res_valid high at T+NUM_SPLITS*(SETTLE+1)+1. Each rejected split k costs (k+1)*(SETTLE+1) cycles before returning to WAIT_CAND.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; no res_valid is produced.
  - A same-cycle cand_valid is not accepted (cand_ready is forced low).
  - abort in DONE discards the verdict.
- Counters: tries never exceeds MAX_TRIES and never wraps; split_sel never exceeds NUM_SPLITS-1.
- Special case: NUM_SPLITS=1 → split_sel stays 0.
- Mid-operation reset: immediate return to the reset values above, regardless of state.

Test Plan:
1. NUM_SPLITS=4, SETTLE=1, split_x tied 1.
   - Stimulus: start, then cand_valid at cycle T.
   - Required: cand_latch at T+1; split_sel steps 0,1,2,3; res_valid at T+9 with res_pass=1, res_tries=1, res_fail_idx=0.
2. Two candidates.
   - Stimulus: first candidate fails at split_sel=2 (split_x=0); second passes everywhere.
   - Required: two cand_latch pulses; the first candidate's CHECK at sel 2 returns to WAIT_CAND; final res_pass=1, res_tries=2.
3. MAX_TRIES=3, split_x tied 0.
   - Required: three accepts, then res_valid with res_pass=0, res_tries=3, res_fail_idx=0.
   - Required: cand_ready stays low after the third accept.
4. Backpressure: hold res_ready=0 for 5 cycles in DONE and pulse start.
   - Required: res_valid and all result outputs unchanged; start ignored.
   - Required: after res_ready=1, busy=0 the next cycle.
5. abort asserted in SETTLE, with cand_valid=1 during the following IDLE.
   - Required: IDLE next cycle, res_valid never asserts, cand_ready=0.
   - Required: a new start restarts with tries counting from 1.
6. rst_n driven low asynchronously in CHECK (between clock edges).
   - Required: busy, split_sel and res_* go to 0 without waiting for a clock edge; after release, the block sits in IDLE until start.
